tile_out_collector: RTL

//  Receive end of the PE tile output interface: consumes the per-cycle c/valid/control beats leaving a tile column.

---
 rtl/tile_collect_pkg.sv | 45 ++++
 rtl/tile_collect_fifo.sv | 48 ++++
 rtl/tile_out_collector.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tile_collect_pkg.sv
// Shared widths, FIFO entry layout and the rounding/saturating shift used by the tile output collector.
package tile_collect_pkg;

  localparam int C_W_DEF     = 19;
  localparam int SHIFT_W_DEF = 6;
  localparam int OUT_W_DEF   = 8;
  localparam int SH_W        = $clog2(C_W_DEF);

  typedef struct packed {
    logic [OUT_W_DEF-1:0] data;
    logic                 last;
    logic                 sat;
  } entry_t;

  typedef struct packed {
    logic [OUT_W_DEF-1:0] data;
    logic                 sat;
  } rs_t;

  localparam logic signed [C_W_DEF:0] Y_HI = (C_W_DEF+1)'(2**(OUT_W_DEF-1) - 1);
  localparam logic signed [C_W_DEF:0] Y_LO = (C_W_DEF+1)'(-(2**(OUT_W_DEF-1)));

  // Arithmetic right shift with round-half-up, clamped shift, then clip to the output range.
  function automatic rs_t round_shift_sat(input logic [C_W_DEF-1:0]     c,
                                          input logic [SHIFT_W_DEF-1:0] s);
    logic [SH_W-1:0]          sh;
    logic signed [C_W_DEF:0]  y;
    rs_t                      r;
    if (s > SHIFT_W_DEF'(C_W_DEF - 1)) sh = SH_W'(C_W_DEF - 1);
    else                               sh = s[SH_W-1:0];
    y = $signed({c[C_W_DEF-1], c}) >>> sh;
    if (sh != '0) y = y + {{C_W_DEF{1'b0}}, c[sh - 1'b1]};
    r.sat = 1'b0;
    if (y > Y_HI) begin
      y     = Y_HI;
      r.sat = 1'b1;
    end else if (y < Y_LO) begin
      y     = Y_LO;
      r.sat = 1'b1;
    end
    r.data = y[OUT_W_DEF-1:0];
    return r;
  endfunction

endpackage

// File: rtl/tile_collect_fifo.sv
// Show-ahead FIFO of collector entries; push and pop may coincide at any fill level.
module tile_collect_fifo
  import tile_collect_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t wdata_i,
  output entry_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // Head is forced to zero when empty so the stream outputs read zero after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tile_out_collector.sv
// Receive end of a PE tile column: round/shift/saturate, block tagging, buffered stream out.
// Optional clipped-beat statistics counter enabled by defining TILE_COLLECT_STATS_EN.
module tile_out_collector
  import tile_collect_pkg::*;
#(
  parameter int C_W        = C_W_DEF,
  parameter int SHIFT_W    = SHIFT_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int DEPTH      = 8,
  parameter int BLOCK_ROWS = 16,
  parameter int CNT_W      = 16
) (
  input  logic               clock,
  input  logic               RST,
  input  logic [C_W-1:0]     io_in_c,
  input  logic               io_in_valid,
  input  logic               io_in_control_propagate,
  input  logic [SHIFT_W-1:0] io_in_control_shift,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [OUT_W-1:0]   o_data,
  output logic               o_last,
  output logic               o_sat,
  output logic               overflow,
  input  logic               clr_overflow,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [CNT_W-1:0]   clip_cnt
);

  localparam int RW = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;

  logic          s1_valid_q;
  entry_t        s1_entry_q, s1_entry_d;
  logic [RW-1:0] row_ctr_q, row_ctr_d;
  logic          prev_prop_q, first_beat_q;
  logic          overflow_q;
  logic [CNT_W-1:0] drop_cnt_q;

  rs_t           rs;
  logic [RW-1:0] row_cur;
  logic          push, pop, drop, fifo_full, fifo_empty;
  entry_t        head;

  always_comb begin
    rs         = round_shift_sat(io_in_c, io_in_control_shift);
    row_cur    = (!first_beat_q && (io_in_control_propagate != prev_prop_q)) ? '0 : row_ctr_q;
    s1_entry_d = '{data: rs.data, last: (row_cur == RW'(BLOCK_ROWS - 1)), sat: rs.sat};
    row_ctr_d  = s1_entry_d.last ? '0 : row_cur + RW'(1);
  end

  // Stream handshake: a beat transfers on a rising clock edge where o_valid && o_ready; while
  // o_valid is high and o_ready low, o_data/o_last/o_sat stay unchanged.
  assign pop  = o_valid && o_ready;
  assign push = s1_valid_q && (!fifo_full || pop);
  assign drop = s1_valid_q && !push;

  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      s1_valid_q   <= 1'b0;
      s1_entry_q   <= '0;
      row_ctr_q    <= '0;
      prev_prop_q  <= 1'b0;
      first_beat_q <= 1'b1;
    end else begin
      s1_valid_q <= io_in_valid;
      if (io_in_valid) begin
        s1_entry_q   <= s1_entry_d;
        row_ctr_q    <= row_ctr_d;
        prev_prop_q  <= io_in_control_propagate;
        first_beat_q <= 1'b0;
      end
    end
  end

  // The clear wins over a drop in the same cycle, so that drop is never counted.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr_overflow) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

`ifdef TILE_COLLECT_STATS_EN
  logic [CNT_W-1:0] clip_cnt_q;

  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      clip_cnt_q <= '0;
    end else if (clr_overflow) begin
      clip_cnt_q <= '0;
    end else if (push && s1_entry_q.sat && (clip_cnt_q != '1)) begin
      clip_cnt_q <= clip_cnt_q + CNT_W'(1);
    end
  end

  assign clip_cnt = clip_cnt_q;
`else
  assign clip_cnt = '0;
`endif

  tile_collect_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (RST),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (s1_entry_q),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_valid  = !fifo_empty;
  assign o_data   = head.data;
  assign o_last   = head.last;
  assign o_sat    = head.sat;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
